// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types for the memory-port arbiter: FSM state encoding and the
// requester identifiers used by the winner-select logic and the last-grant
// register.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN is consumed by the arbiter
// files, not by this package.
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2,
    RESP      = 2'd3
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_INST = 1'b0;
  localparam req_id_t REQ_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch, load/store and unified memory bus signals around the
// arbiter.
//   master : arbiter view (drives mem_* and the fetch/LSU completions)
//   slave  : environment view (core requesters and memory)
// Parameters: DATA_WIDTH (address/data width), BYTE_DATA_WIDTH (byte lanes).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = DATA_WIDTH / 8
);

  // fetch side
  logic                       inst_req;
  logic [DATA_WIDTH-1:0]      inst_addr;
  logic                       inst_valid;
  logic [DATA_WIDTH-1:0]      inst_data;
  // load/store side
  logic                       data_req;
  logic                       data_we;
  logic [BYTE_DATA_WIDTH-1:0] byte_enable;
  logic [DATA_WIDTH-1:0]      data_addr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic                       data_valid;
  logic [DATA_WIDTH-1:0]      rdata;
  // unified memory bus
  logic                       mem_req;
  logic                       mem_we;
  logic [BYTE_DATA_WIDTH-1:0] mem_be;
  logic [DATA_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       mem_ack;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_valid, inst_data,
    input  data_req, data_we, byte_enable, data_addr, wdata,
    output data_valid, rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_valid, inst_data,
    output data_req, data_we, byte_enable, data_addr, wdata,
    input  data_valid, rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select between the fetch and LSU requesters.
// Build macro MEM_ARB_ROUND_ROBIN_EN: when defined, a tie goes to the
// requester not granted last (last_grant_i port present); otherwise a tie
// always goes to the LSU.
// Ports:
//   inst_req_i, data_req_i : pending requests
//   last_grant_i           : previous winner (round-robin build only)
//   grant_valid_o          : at least one request pending
//   grant_id_o             : winner (REQ_INST / REQ_DATA)
// ---------------------------------------------------------------------------
module mem_arb_pick
  import core_pkg::*;
(
  input  logic    inst_req_i,
  input  logic    data_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  req_id_t last_grant_i,
`endif
  output logic    grant_valid_o,
  output req_id_t grant_id_o
);

  always_comb begin
    grant_valid_o = inst_req_i | data_req_i;
    grant_id_o    = REQ_DATA;
    if (inst_req_i && data_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_id_o = (last_grant_i == REQ_INST) ? REQ_DATA : REQ_INST;
`else
      grant_id_o = REQ_DATA;
`endif
    end else if (inst_req_i) begin
      grant_id_o = REQ_INST;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory bus between instruction fetch and load/store. One
// transaction at a time: grant, register the command, hold mem_req until
// mem_ack, then pulse the owner's valid for one cycle with registered data.
// Build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (default: LSU wins ties, no last-grant register).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mem_port_arbiter_if.master (fetch, LSU and memory bus signals)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = DATA_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  arb_state_t                 state_q;
  logic                       mem_req_q;
  logic                       mem_we_q;
  logic [BYTE_DATA_WIDTH-1:0] mem_be_q;
  logic [DATA_WIDTH-1:0]      mem_addr_q;
  logic [DATA_WIDTH-1:0]      mem_wdata_q;
  logic                       inst_valid_q;
  logic                       data_valid_q;
  logic [DATA_WIDTH-1:0]      inst_data_q;
  logic [DATA_WIDTH-1:0]      rdata_q;

  logic                       grant_valid;
  req_id_t                    grant_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t                    last_grant_q;
`endif

  mem_arb_pick u_pick (
    .inst_req_i    (bus.inst_req),
    .data_req_i    (bus.data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant_i  (last_grant_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // state | meaning
  // IDLE      | waiting for a request; mem_ack ignored
  // INST_BUSY | fetch command on the bus, waiting for mem_ack
  // DATA_BUSY | load/store command on the bus, waiting for mem_ack
  // RESP      | one-cycle valid pulse; no grant so a held req is not reissued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_data_q  <= '0;
      rdata_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_DATA;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            mem_req_q <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= grant_id;
`endif
            if (grant_id == REQ_DATA) begin
              state_q     <= DATA_BUSY;
              mem_we_q    <= bus.data_we;
              mem_be_q    <= bus.byte_enable;
              mem_addr_q  <= bus.data_addr;
              mem_wdata_q <= bus.wdata;
            end else begin
              state_q     <= INST_BUSY;
              mem_we_q    <= 1'b0;
              mem_be_q    <= '1;
              mem_addr_q  <= bus.inst_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        INST_BUSY: begin
          if (bus.mem_ack) begin
            inst_data_q  <= bus.mem_rdata;
            inst_valid_q <= 1'b1;
            mem_req_q    <= 1'b0;
            state_q      <= RESP;
          end
        end
        DATA_BUSY: begin
          // Read data is captured on stores too; the LSU just ignores it.
          if (bus.mem_ack) begin
            rdata_q      <= bus.mem_rdata;
            data_valid_q <= 1'b1;
            mem_req_q    <= 1'b0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          inst_valid_q <= 1'b0;
          data_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_data  = inst_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Table rows are applied one per cycle
// just after a rising edge; expectations describe the outputs just after the
// following edge. Multi-cycle tie and reset cases are hand-written.
// Honours MEM_ARB_ROUND_ROBIN_EN for tie-order expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  be;
    logic [31:0] data_addr;
    logic [31:0] wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        x_mem_req;
    logic        x_mem_we;
    logic [3:0]  x_mem_be;
    logic [31:0] x_mem_addr;
    logic [31:0] x_mem_wdata;
    logic        x_inst_valid;
    logic [31:0] x_inst_data;
    logic        x_data_valid;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.data_req    = 1'b0;
    bus.data_we     = 1'b0;
    bus.byte_enable = '0;
    bus.data_addr   = '0;
    bus.wdata       = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  task automatic add(input string nm,
                     input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dwe, input logic [3:0] be,
                     input logic [31:0] da, input logic [31:0] wd,
                     input logic ack, input logic [31:0] mrd,
                     input logic xreq, input logic xwe, input logic [3:0] xbe,
                     input logic [31:0] xaddr, input logic [31:0] xwd,
                     input logic xiv, input logic [31:0] xid,
                     input logic xdv, input logic [31:0] xrd);
    vec_t v;
    v.name = nm; v.inst_req = ir; v.inst_addr = ia; v.data_req = dr;
    v.data_we = dwe; v.be = be; v.data_addr = da; v.wdata = wd;
    v.mem_ack = ack; v.mem_rdata = mrd;
    v.x_mem_req = xreq; v.x_mem_we = xwe; v.x_mem_be = xbe;
    v.x_mem_addr = xaddr; v.x_mem_wdata = xwd; v.x_inst_valid = xiv;
    v.x_inst_data = xid; v.x_data_valid = xdv; v.x_rdata = xrd;
    vecs.push_back(v);
  endtask

  // Wait (bounded) for mem_req, check the address, ack it and check the
  // completion pulse lands on the expected requester.
  task automatic run_txn(input string nm, input logic exp_data,
                         input logic [31:0] exp_addr, input logic [31:0] rd);
    bit found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.mem_req === 1'b1) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: mem_req never rose", nm);
    end else begin
      chk({nm, "_addr"}, bus.mem_addr, exp_addr);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd;
      @(posedge clk); #1;
      bus.mem_ack   = 1'b0;
      chk({nm, "_inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, ~exp_data});
      chk({nm, "_data_valid"}, {31'd0, bus.data_valid}, {31'd0, exp_data});
      chk({nm, "_ret"}, exp_data ? bus.rdata : bus.inst_data, rd);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req",    {31'd0, bus.mem_req},    32'd0);
    chk("rst_mem_addr",   bus.mem_addr,            32'd0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("rst_rdata",      bus.rdata,               32'd0);
    chk("rst_inst_data",  bus.inst_data,           32'd0);
    rst = 1'b1;

    //   name       ir ia      dr we be    da         wd           ack mrd
    //              req we be    addr       wdata        iv idata        dv rdata
    add("f_grant",  1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,
                    1, 0, 4'hF, 32'h100, 32'h0,       0, 32'h0,        0, 32'h0);
    add("f_busy",   1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,
                    1, 0, 4'hF, 32'h100, 32'h0,       0, 32'h0,        0, 32'h0);
    add("f_ack",    1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h00500093,
                    0, 0, 4'hF, 32'h100, 32'h0,       1, 32'h00500093, 0, 32'h0);
    add("f_held",   1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,
                    0, 0, 4'hF, 32'h100, 32'h0,       0, 32'h00500093, 0, 32'h0);
    add("idle_ack", 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h77777777,
                    0, 0, 4'hF, 32'h100, 32'h0,       0, 32'h00500093, 0, 32'h0);
    add("st_grant", 0, 32'h0,   1, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 32'h0,
                    1, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 32'h00500093, 0, 32'h0);
    add("st_ack",   0, 32'h0,   1, 0, 4'h8, 32'h9999, 32'h1,        1, 32'h12345678,
                    0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 32'h00500093, 1, 32'h12345678);
    add("st_resp",  0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h0,
                    0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 32'h00500093, 0, 32'h12345678);
    add("ld_grant", 0, 32'h0,   1, 0, 4'hC, 32'h40,  32'h55,       0, 32'h0,
                    1, 0, 4'hC, 32'h40,  32'h55,       0, 32'h00500093, 0, 32'h12345678);
    add("ld_ack",   0, 32'h0,   1, 0, 4'hC, 32'h40,  32'h55,       1, 32'hCAFEF00D,
                    0, 0, 4'hC, 32'h40,  32'h55,       0, 32'h00500093, 1, 32'hCAFEF00D);
    add("ld_resp",  0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,
                    0, 0, 4'hC, 32'h40,  32'h55,       0, 32'h00500093, 0, 32'hCAFEF00D);
    add("ld_idle",  0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,
                    0, 0, 4'hC, 32'h40,  32'h55,       0, 32'h00500093, 0, 32'hCAFEF00D);

    foreach (vecs[i]) begin
      bus.inst_req    = vecs[i].inst_req;
      bus.inst_addr   = vecs[i].inst_addr;
      bus.data_req    = vecs[i].data_req;
      bus.data_we     = vecs[i].data_we;
      bus.byte_enable = vecs[i].be;
      bus.data_addr   = vecs[i].data_addr;
      bus.wdata       = vecs[i].wdata;
      bus.mem_ack     = vecs[i].mem_ack;
      bus.mem_rdata   = vecs[i].mem_rdata;
      @(posedge clk); #1;
      chk({vecs[i].name, ".mem_req"},    {31'd0, bus.mem_req},    {31'd0, vecs[i].x_mem_req});
      chk({vecs[i].name, ".mem_we"},     {31'd0, bus.mem_we},     {31'd0, vecs[i].x_mem_we});
      chk({vecs[i].name, ".mem_be"},     {28'd0, bus.mem_be},     {28'd0, vecs[i].x_mem_be});
      chk({vecs[i].name, ".mem_addr"},   bus.mem_addr,            vecs[i].x_mem_addr);
      chk({vecs[i].name, ".mem_wdata"},  bus.mem_wdata,           vecs[i].x_mem_wdata);
      chk({vecs[i].name, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, vecs[i].x_inst_valid});
      chk({vecs[i].name, ".inst_data"},  bus.inst_data,           vecs[i].x_inst_data);
      chk({vecs[i].name, ".data_valid"}, {31'd0, bus.data_valid}, {31'd0, vecs[i].x_data_valid});
      chk({vecs[i].name, ".rdata"},      bus.rdata,               vecs[i].x_rdata);
    end
    idle_inputs();

    // Ties: both requesters raise in the same cycle.
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h300;
    bus.data_req    = 1'b1;
    bus.data_we     = 1'b0;
    bus.byte_enable = 4'hF;
    bus.data_addr   = 32'h400;
    @(posedge clk); #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    run_txn("rr_t1", 1'b0, 32'h300, 32'hA0000001);
    run_txn("rr_t2", 1'b1, 32'h400, 32'hA0000002);
    run_txn("rr_t3", 1'b0, 32'h300, 32'hA0000003);
    run_txn("rr_t4", 1'b1, 32'h400, 32'hA0000004);
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
`else
    run_txn("fp_t1", 1'b1, 32'h400, 32'hB0000001);
    bus.data_req = 1'b0;
    run_txn("fp_t2", 1'b0, 32'h300, 32'hB0000002);
    bus.inst_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("tie_quiet_mem_req", {31'd0, bus.mem_req}, 32'd0);

    // Reset during DATA_BUSY, then a stale ack after release.
    bus.data_req    = 1'b1;
    bus.data_we     = 1'b1;
    bus.byte_enable = 4'h5;
    bus.data_addr   = 32'h800;
    bus.wdata       = 32'h11223344;
    @(posedge clk); #1;
    chk("mid_busy_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_req",  {31'd0, bus.mem_req},  32'd0);
    chk("mid_rst_mem_addr", bus.mem_addr,          32'd0);
    chk("mid_rst_rdata",    bus.rdata,             32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("late_ack_data_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("late_ack_mem_req",    {31'd0, bus.mem_req},    32'd0);
    @(posedge clk); #1;
    chk("late_ack_data_valid2", {31'd0, bus.data_valid}, 32'd0);
    chk("late_ack_rdata",       bus.rdata,               32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
